memc_drain: RTL and testbench

- Output-side collector for the DIM x DIM systolic matmul array.
- The array emits result columns skewed: lane x lags lane 0 by x enabled cycles.
- This block de-skews the stream into a DIM x DIM result buffer, then lets the host/CSR side read whole rows through a registered read port.
- It is the drain counterpart to the row-loading/skewing input memories.

---
 rtl/memc_drain.sv | 92 +++++++++
 tb/tb_memc_drain.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/memc_drain.sv
// memc_drain: de-skews systolic array result columns into a DIM x DIM
// buffer, then serves whole-row reads through a registered port.
module memc_drain #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         start,
    input  logic                         Cin_valid,
    input  logic [DIM-1:0][BITS_C-1:0]   Cin,
    input  logic                         rd_en,
    input  logic [$clog2(DIM)-1:0]       rd_row,
    input  logic                         release_buf,
    output logic [DIM-1:0][BITS_C-1:0]   Cout,
    output logic                         rd_valid,
    output logic                         busy,
    output logic                         full
);
    localparam int RW = $clog2(DIM);
    localparam int CW = RW + 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FULL} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     step;
    logic              cap;
    logic              rd_go;
    logic [DIM-1:0]    we;
    logic [RW-1:0]     row [DIM];
    logic [BITS_C-1:0] mem [DIM][DIM];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ARMED;
            ARMED:   if (en && Cin_valid) state_nx = CAPTURE;
            CAPTURE: if (en && cnt == CW'(2*DIM-2)) state_nx = FULL;
            FULL:    if (release_buf) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ARMED) || (state == CAPTURE);
        full = (state == FULL);
    end

    // ARMED supplies step 0; CAPTURE continues from the counter
    assign cap   = ((state == ARMED) && en && Cin_valid) ||
                   ((state == CAPTURE) && en);
    assign step  = (state == CAPTURE) ? cnt : '0;
    assign rd_go = rd_en && (state == FULL);

    always_ff @(posedge clk) begin
        if (rst)      cnt <= '0;
        else if (cap) cnt <= step + CW'(1);
    end

    // lane x carries row k-x at step k
    for (genvar x = 0; x < DIM; x++) begin : g_lane
        logic [CW-1:0] d;
        assign d      = step - CW'(x);
        assign we[x]  = cap && (step >= CW'(x)) && (d < CW'(DIM));
        assign row[x] = d[RW-1:0];
    end

    always_ff @(posedge clk) begin
        for (int x = 0; x < DIM; x++) begin
            if (we[x]) mem[row[x]][x] <= Cin[x];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Cout     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_go;
            if (rd_go) begin
                for (int c = 0; c < DIM; c++) Cout[c] <= mem[rd_row][c];
            end
        end
    end
endmodule

// File: tb/tb_memc_drain.sv
// Randomized scoreboard bench for memc_drain: the golden matrix is
// skewed onto the lanes and row reads are checked by a monitor.
module tb_memc_drain;
    localparam int BITS_C = 16;
    localparam int DIM    = 8;
    localparam int RW     = $clog2(DIM);
    localparam int NB     = DIM * BITS_C;

    logic                       clk = 0;
    logic                       rst, en, start, Cin_valid;
    logic [DIM-1:0][BITS_C-1:0] Cin;
    logic                       rd_en, release_buf;
    logic [RW-1:0]              rd_row;
    logic [DIM-1:0][BITS_C-1:0] Cout;
    logic                       rd_valid, busy, full;

    int checks = 0;
    int errors = 0;

    logic [BITS_C-1:0] gold [DIM][DIM];
    logic [NB-1:0]     exp_q [$];
    logic [NB-1:0]     last_row;

    memc_drain #(.BITS_C(BITS_C), .DIM(DIM)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .Cin_valid(Cin_valid), .Cin(Cin), .rd_en(rd_en),
        .rd_row(rd_row), .release_buf(release_buf),
        .Cout(Cout), .rd_valid(rd_valid), .busy(busy), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [NB-1:0] got,
                       input logic [NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // monitor: every rd_valid must match the oldest outstanding read
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got rd_valid=1 row %h expected no read", Cout);
            end else begin
                logic [NB-1:0] e;
                e = exp_q.pop_front();
                if (Cout !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %h expected %h", Cout, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [NB-1:0] row_of(input int r);
        logic [NB-1:0] v;
        for (int c = 0; c < DIM; c++) v[c*BITS_C +: BITS_C] = gold[r][c];
        return v;
    endfunction

    task automatic fill(input int mode, input int off);
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                gold[r][c] = (mode == 0) ? BITS_C'(100*r + c + off)
                                         : BITS_C'($urandom);
    endtask

    task automatic garbage();
        for (int x = 0; x < DIM; x++) Cin[x] = 16'h7FFF;
    endtask

    task automatic capture(input int mode, input int pre, input int abort_at);
        int g;
        start = 1; Cin_valid = 1; en = 1'($urandom);
        cyc();
        chk("armed_busy", NB'(busy), NB'(1));
        start = 0;
        for (int i = 0; i < pre; i++) begin
            en = (i != 2);
            Cin_valid = (i == 2);
            rd_en = i[0];
            rd_row = RW'($urandom);
            garbage();
            cyc();
            chk("arm_wait_busy", NB'({full, busy}), NB'(2'b01));
        end
        rd_en = 0;
        for (int k = 0; k <= 2*DIM-2; k++) begin
            g = (mode == 1) ? ((k == 3 || k == 10) ? 3 : 0)
              : (mode == 2) ? int'($urandom_range(0, 2)) * int'($urandom_range(0, 1))
              : 0;
            for (int j = 0; j < g; j++) begin
                en = 0; Cin_valid = 1'($urandom); garbage();
                cyc();
                chk("gap_state", NB'({full, busy}), NB'(2'b01));
            end
            en = 1;
            Cin_valid = (k == 0) ? 1'b1 : 1'($urandom);
            for (int x = 0; x < DIM; x++)
                Cin[x] = (k - x >= 0 && k - x < DIM) ? gold[k-x][x]
                                                     : BITS_C'($urandom);
            if (k == abort_at) rst = 1;
            cyc();
            if (k == abort_at) begin
                rst = 0; en = 0;
                chk("rst_flags", NB'({full, busy, rd_valid}), NB'(0));
                chk("rst_cout", Cout, '0);
                return;
            end
            chk("step_state", NB'({full, busy}),
                (k == 2*DIM-2) ? NB'(2'b10) : NB'(2'b01));
        end
        en = 0;
    endtask

    task automatic read_all(input bit rel);
        int ord [DIM];
        int r, t, s;
        for (int i = 0; i < DIM; i++) ord[i] = i;
        for (int i = 0; i < DIM; i++) begin
            s = $urandom_range(DIM-1);
            t = ord[i]; ord[i] = ord[s]; ord[s] = t;
        end
        for (int n = 0; n < DIM + 4; n++) begin
            r = (n < DIM) ? ord[n] : int'($urandom_range(DIM-1));
            rd_en = 1; rd_row = RW'(r);
            exp_q.push_back(row_of(r));
            last_row = row_of(r);
            cyc();
            if ($urandom_range(2) == 0) begin
                rd_en = 0;
                cyc();
                chk("idle_rdv", NB'(rd_valid), NB'(0));
                chk("cout_hold", Cout, last_row);
            end
        end
        rd_en = 0;
        release_buf = rel;
        cyc();
        release_buf = 0;
        if (rel) chk("released", NB'({full, busy}), NB'(0));
    endtask

    initial begin
        rst = 1; en = 0; start = 0; Cin_valid = 0; rd_en = 0;
        rd_row = '0; release_buf = 0; garbage();
        cyc(); cyc();
        rst = 0;
        chk("reset_flags", NB'({full, busy, rd_valid}), NB'(0));
        chk("reset_cout", Cout, '0);

        fill(0, 0); capture(0, 0, -1); read_all(1);
        fill(0, 0); capture(1, 0, -1); read_all(1);
        fill(1, 0); capture(0, 5, -1); read_all(1);

        fill(1, 0);
        gold[DIM-1][0] = 16'h8000;
        gold[0][DIM-1] = 16'h7FFF;
        capture(2, 0, -1); read_all(1);

        fill(1, 0); capture(2, 1, -1); read_all(0);
        start = 1;
        cyc();
        start = 0;
        chk("start_in_full", NB'({full, busy}), NB'(2'b10));
        rd_en = 1; rd_row = RW'(5); release_buf = 1;
        exp_q.push_back(row_of(5));
        cyc();
        rd_en = 0; release_buf = 0;
        chk("rd_release", NB'({full, busy, rd_valid}), NB'(3'b001));
        rd_en = 1;
        cyc();
        rd_en = 0;
        chk("idle_read", NB'(rd_valid), NB'(0));
        fill(0, 1000); capture(0, 0, -1); read_all(1);

        fill(1, 0); capture(0, 0, 6);
        fill(1, 0); capture(0, 0, -1); read_all(1);
        for (int i = 0; i < 3; i++) begin
            fill(1, 0); capture(2, $urandom_range(0, 3), -1); read_all(1);
        end

        cyc(); cyc();
        chk("queue_drained", NB'(exp_q.size()), NB'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
